// File: rtl/tt_fetch_pkg.sv
// Shared constants and uio control decoding for the instruction-fetch block.
// Sizes, uio bit positions and the fixed output-enable pattern live here.
package tt_fetch_pkg;

  localparam int unsigned MEM_WORDS  = 16;
  localparam int unsigned FIFO_DEPTH = 4;

  localparam int unsigned UIO_WR_EN     = 0;
  localparam int unsigned UIO_PC_VALID  = 1;
  localparam int unsigned UIO_FLUSH     = 2;
  localparam int unsigned UIO_OUT_READY = 3;
  localparam int unsigned UIO_PC_READY  = 4;
  localparam int unsigned UIO_OUT_VALID = 5;
  localparam int unsigned UIO_FULL      = 6;
  localparam int unsigned UIO_EMPTY     = 7;

  localparam logic [7:0] UIO_OE_VALUE = 8'hF0;

  typedef struct packed {
    logic out_ready;
    logic flush;
    logic pc_valid;
    logic wr_en;
  } uio_ctrl_t;

  function automatic uio_ctrl_t decode_uio(input logic [3:0] uio);
    uio_ctrl_t c;
    c.wr_en     = uio[UIO_WR_EN];
    c.pc_valid  = uio[UIO_PC_VALID];
    c.flush     = uio[UIO_FLUSH];
    c.out_ready = uio[UIO_OUT_READY];
    return c;
  endfunction

endpackage

// File: rtl/tt_um_instr_fetch_if.sv
// Push/pop/flush bus between the fetch control logic (master) and its buffer (slave).
interface tt_um_instr_fetch_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             push;
  logic             pop;
  logic             flush;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;

  modport master (
    output push, pop, flush, wdata,
    input  rdata, full, empty, count
  );

  modport slave (
    input  push, pop, flush, wdata,
    output rdata, full, empty, count
  );

endinterface

// File: rtl/tt_um_instr_fetch_fifo.sv
// Circular buffer of fetched instructions; flush wins over any push/pop in the same cycle.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tt_um_instr_fetch_if.slave   f
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] buf_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;
  logic             full, empty;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    do_push = 1'b0;
    do_pop  = 1'b0;
    if (f.flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      do_push = f.push & ~full;
      do_pop  = f.pop & ~empty;
      if (do_push) wr_d = nxt(wr_q);
      if (do_pop)  rd_d = nxt(rd_q);
      if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
      else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (do_push) buf_q[wr_q] <= f.wdata;
    end
  end

  assign f.rdata = buf_q[rd_q];
  assign f.full  = full;
  assign f.empty = empty;
  assign f.count = cnt_q;

endmodule

// File: rtl/tt_um_instr_fetch.sv
// Instruction fetch unit: loadable local instruction memory, PC-addressed reads,
// and a small output buffer with valid/ready handshake on the TinyTapeout pins.
module tt_um_instr_fetch #(
  parameter int unsigned MEM_WORDS  = tt_fetch_pkg::MEM_WORDS,
  parameter int unsigned FIFO_DEPTH = tt_fetch_pkg::FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  import tt_fetch_pkg::*;

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [7:0]    mem_q [MEM_WORDS];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          rd_pending_q, rd_pending_d;

  uio_ctrl_t     ctrl;
  logic          live;
  logic          pc_ready, accept, out_valid;
  logic [CW:0]   occupancy;
  logic          unused_uio;

  tt_um_instr_fetch_if #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) fq ();

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .f     (fq)
  );

  assign ctrl       = decode_uio(uio_in[3:0]);
  assign unused_uio = &{1'b0, uio_in[7:4]};

  // rst_n gates the handshake outputs so they read idle while reset is held.
  assign live      = ena & rst_n;
  assign occupancy = {1'b0, fq.count} + (CW+1)'(rd_pending_q);
  assign pc_ready  = live & ~ctrl.wr_en & ~ctrl.flush & (occupancy < (CW+1)'(FIFO_DEPTH));
  assign accept    = ctrl.pc_valid & pc_ready;
  assign out_valid = live & ~fq.empty;

  assign fq.push  = live & rd_pending_q;
  assign fq.pop   = out_valid & ctrl.out_ready;
  assign fq.flush = live & ctrl.flush;
  assign fq.wdata = mem_q[rd_addr_q];

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_addr_d    = rd_addr_q;
    rd_pending_d = rd_pending_q;
    if (live) begin
      if (ctrl.wr_en)
        wr_ptr_d = (wr_ptr_q == AW'(MEM_WORDS - 1)) ? '0 : wr_ptr_q + AW'(1);
      // A pending read always drains on the next edge; accept re-arms it.
      rd_pending_d = accept;
      if (accept) rd_addr_d = ui_in[2 +: AW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_addr_q    <= '0;
      rd_pending_q <= 1'b0;
      for (int unsigned i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_addr_q    <= rd_addr_d;
      rd_pending_q <= rd_pending_d;
      if (live && ctrl.wr_en) mem_q[wr_ptr_q] <= ui_in;
    end
  end

  always_comb begin
    uio_out                = '0;
    uio_out[UIO_PC_READY]  = pc_ready;
    uio_out[UIO_OUT_VALID] = out_valid;
    uio_out[UIO_FULL]      = fq.full;
    uio_out[UIO_EMPTY]     = fq.empty;
  end

  assign uo_out = out_valid ? fq.rdata : '0;
  assign uio_oe = UIO_OE_VALUE;

endmodule

// File: tb/tb_tt_um_instr_fetch.sv
// Directed plus randomized bench for tt_um_instr_fetch against a queue-based reference model.
module tb_tt_um_instr_fetch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena_r;
  logic [7:0] ui_r, uio_r;
  logic [7:0] uo_out, uio_out, uio_oe;

  int checks = 0;
  int errors = 0;

  // Reference model: memory image, write pointer, buffered instructions, pending read.
  logic [7:0] mem_m [16];
  int         wp_m;
  logic [7:0] q_m [$];
  bit         pend_m;
  int         raddr_m;

  logic       last_rdy;
  logic [7:0] last_uo, last_uio;
  logic [7:0] obs [32];
  int         acc;

  tt_um_instr_fetch #(.MEM_WORDS(16), .FIFO_DEPTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena_r),
    .ui_in   (ui_r),
    .uio_in  (uio_r),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic drive(input logic e, input logic [7:0] u, input logic [7:0] c);
    ena_r = e;
    ui_r  = u;
    uio_r = c;
  endtask

  task automatic model_reset();
    q_m.delete();
    pend_m  = 1'b0;
    raddr_m = 0;
    wp_m    = 0;
    for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
  endtask

  // One clock: check outputs at the falling edge, advance the model at the rising edge.
  task automatic step();
    logic       wr, pv, fl, ordy, exp_rdy, exp_ov;
    logic [7:0] exp_uo, pushv;
    int         occ;
    wr   = uio_r[0];
    pv   = uio_r[1];
    fl   = uio_r[2];
    ordy = uio_r[3];
    @(negedge clk);
    occ     = q_m.size() + int'(pend_m);
    exp_rdy = ena_r && !wr && !fl && (occ < 4);
    exp_ov  = ena_r && (q_m.size() != 0);
    exp_uo  = exp_ov ? q_m[0] : 8'h00;
    chk("uo_out", uo_out, exp_uo);
    chk("uio_out", uio_out, {q_m.size() == 0, q_m.size() == 4, exp_ov, exp_rdy, 4'b0000});
    chk("uio_oe", uio_oe, 8'hF0);
    last_rdy = uio_out[4];
    last_uo  = uo_out;
    last_uio = uio_out;
    @(posedge clk);
    if (ena_r) begin
      pushv = mem_m[raddr_m];
      if (fl) begin
        q_m.delete();
        pend_m = 1'b0;
      end else begin
        if (exp_ov && ordy) void'(q_m.pop_front());
        if (pend_m) q_m.push_back(pushv);
        pend_m = exp_rdy && pv;
        if (pend_m) raddr_m = int'(ui_r[5:2]);
      end
      if (wr) begin
        mem_m[wp_m] = ui_r;
        wp_m = (wp_m + 1) % 16;
      end
    end
    #1;
  endtask

  initial begin
    logic [7:0] c;
    rst_n = 1'b0;
    drive(1'b1, 8'h00, 8'h00);
    model_reset();
    #3;
    chk("rst_uo", uo_out, 8'h00);
    chk("rst_uio", uio_out, 8'h80);
    chk("rst_oe", uio_oe, 8'hF0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Load 16 words; wr_ptr should wrap back to 0.
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 8'(8'h10 + k), 8'h01);
      step();
    end

    // Stream every word with out_ready held high.
    for (int k = 0; k < 18; k++) begin
      if (k < 16) drive(1'b1, 8'(k * 4), 8'h0A);
      else        drive(1'b1, 8'h00, 8'h08);
      step();
      obs[k] = last_uo;
    end
    for (int k = 0; k < 16; k++) chk("stream", obs[k + 2], 8'(8'h10 + k));

    // Backpressure: only four PCs fit.
    acc = 0;
    for (int j = 0; j < 8; j++) begin
      drive(1'b1, 8'(j * 4), 8'h02);
      step();
      if (last_rdy) acc++;
    end
    chk("bp_accepted", 8'(acc), 8'd4);
    chk("bp_full", {7'd0, uio_out[6]}, 8'd1);
    chk("bp_pc_ready", {7'd0, uio_out[4]}, 8'd0);
    for (int j = 0; j < 5; j++) begin
      drive(1'b1, 8'h00, 8'h08);
      step();
      obs[j] = last_uo;
    end
    for (int j = 0; j < 4; j++) chk("bp_drain", obs[j], 8'(8'h10 + j));
    chk("bp_drained", obs[4], 8'h00);

    // Flush with three entries buffered and one read pending.
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, 8'(8'h20 + j * 4), 8'h02);
      step();
    end
    chk("fl_pre_valid", {7'd0, uio_out[5]}, 8'd1);
    drive(1'b1, 8'h30, 8'h0E);
    step();
    drive(1'b1, 8'h00, 8'h08);
    step();
    chk("fl_empty", {7'd0, last_uio[7]}, 8'd1);
    chk("fl_out_valid", {7'd0, last_uio[5]}, 8'd0);
    drive(1'b1, 8'h14, 8'h0A); step();
    drive(1'b1, 8'h00, 8'h08); step();
    step();
    chk("fl_refetch", last_uo, 8'h15);
    step();

    // Write and PC together: write wins, lands at the wrapped pointer (word 0).
    drive(1'b1, 8'hA5, 8'h03);
    step();
    chk("prio_pc_ready", {7'd0, last_uio[4]}, 8'd0);
    drive(1'b1, 8'h00, 8'h0A); step();
    drive(1'b1, 8'h00, 8'h08); step();
    step();
    chk("prio_write", last_uo, 8'hA5);
    step();

    // Write on the push edge is not seen; a later fetch sees it.
    drive(1'b1, 8'h04, 8'h02); step();
    drive(1'b1, 8'h77, 8'h01); step();
    drive(1'b1, 8'h00, 8'h08); step();
    chk("same_edge_wr", last_uo, 8'h11);
    drive(1'b1, 8'h04, 8'h0A); step();
    drive(1'b1, 8'h00, 8'h08); step();
    step();
    chk("later_wr", last_uo, 8'h77);
    step();

    // ena low for five cycles with one entry buffered.
    drive(1'b1, 8'h08, 8'h02); step();
    drive(1'b1, 8'h00, 8'h00); step();
    for (int j = 0; j < 5; j++) begin
      drive(1'b0, 8'($urandom), 8'($urandom));
      step();
      chk("ena0_uo", last_uo, 8'h00);
      chk("ena0_ov", {6'd0, last_uio[5:4]}, 8'd0);
    end
    drive(1'b1, 8'h00, 8'h00); step();
    chk("ena_hold", last_uo, 8'h12);
    drive(1'b1, 8'h00, 8'h08); step();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      c = 8'($urandom) & 8'hF0;
      if ($urandom_range(0, 7) == 0)  c[0] = 1'b1;
      if ($urandom_range(0, 1) == 0)  c[1] = 1'b1;
      if ($urandom_range(0, 15) == 0) c[2] = 1'b1;
      if ($urandom_range(0, 2) != 0)  c[3] = 1'b1;
      drive($urandom_range(0, 9) != 0, 8'($urandom), c);
      step();
    end

    // Fill the buffer, then pulse reset between edges.
    for (int j = 0; j < 8; j++) begin
      drive(1'b1, 8'($urandom), 8'h02);
      step();
    end
    chk("ar_full", {7'd0, uio_out[6]}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_uo", uo_out, 8'h00);
    chk("ar_uio", uio_out, 8'h80);
    chk("ar_oe", uio_oe, 8'hF0);
    model_reset();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive(1'b1, 8'(k * 4), 8'h0A);
      else       drive(1'b1, 8'h00, 8'h08);
      step();
      obs[k] = last_uo;
      if (k >= 2) chk("ar_ov", {7'd0, last_uio[5]}, 8'd1);
    end
    for (int k = 0; k < 4; k++) chk("ar_mem_zero", obs[k + 2], 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
